// File: rtl/alu_op_encoder.sv
// Decodes MIPS opcode/funct into the 5-bit aluc control word and queues it in a
// 2-entry skid buffer with valid/ready on both sides. Optional counters: ALUC_STATS_EN.
module alu_op_encoder #(
    parameter int DEPTH = 2
`ifdef ALUC_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] aluc,
    output logic       use_imm,
    output logic       imm_sext,
    output logic       shift_var,
    output logic       illegal
`ifdef ALUC_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_issued,
    output logic [CNT_W-1:0] stat_illegal
`endif
);

    localparam logic [4:0] ALU_ADDU = 5'b00000, ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUBU = 5'b00010, ALU_SUB  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00100, ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110, ALU_NOR  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000, ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_SLL  = 5'b01100, ALU_SRL  = 5'b01101;
    localparam logic [4:0] ALU_SRA  = 5'b01110, ALU_LUI  = 5'b10000;
    localparam logic [1:0] FULL     = 2'(DEPTH);

    typedef struct packed {
        logic [4:0] aluc;
        logic       use_imm;
        logic       imm_sext;
        logic       shift_var;
        logic       illegal;
    } entry_t;

    entry_t     dec;
    entry_t     head_q, head_d, tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    always_comb begin
        dec = '0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000: dec.aluc = ALU_ADD;
                    6'b100001: dec.aluc = ALU_ADDU;
                    6'b100010: dec.aluc = ALU_SUB;
                    6'b100011: dec.aluc = ALU_SUBU;
                    6'b100100: dec.aluc = ALU_AND;
                    6'b100101: dec.aluc = ALU_OR;
                    6'b100110: dec.aluc = ALU_XOR;
                    6'b100111: dec.aluc = ALU_NOR;
                    6'b101010: dec.aluc = ALU_SLT;
                    6'b101011: dec.aluc = ALU_SLTU;
                    6'b000000: dec.aluc = ALU_SLL;
                    6'b000010: dec.aluc = ALU_SRL;
                    6'b000011: dec.aluc = ALU_SRA;
                    6'b000100: begin dec.aluc = ALU_SLL; dec.shift_var = 1'b1; end
                    6'b000110: begin dec.aluc = ALU_SRL; dec.shift_var = 1'b1; end
                    6'b000111: begin dec.aluc = ALU_SRA; dec.shift_var = 1'b1; end
                    default:   dec.illegal = 1'b1;
                endcase
            end
            6'b001000: begin dec.aluc = ALU_ADD;  dec.use_imm = 1'b1; dec.imm_sext = 1'b1; end
            6'b001001: begin dec.aluc = ALU_ADDU; dec.use_imm = 1'b1; dec.imm_sext = 1'b1; end
            6'b001010: begin dec.aluc = ALU_SLT;  dec.use_imm = 1'b1; dec.imm_sext = 1'b1; end
            6'b001011: begin dec.aluc = ALU_SLTU; dec.use_imm = 1'b1; dec.imm_sext = 1'b1; end
            6'b001100: begin dec.aluc = ALU_AND;  dec.use_imm = 1'b1; end
            6'b001101: begin dec.aluc = ALU_OR;   dec.use_imm = 1'b1; end
            6'b001110: begin dec.aluc = ALU_XOR;  dec.use_imm = 1'b1; end
            6'b001111: begin dec.aluc = ALU_LUI;  dec.use_imm = 1'b1; end
            // Load/store address generation is an unchecked add of the sign-extended offset.
            6'b100011, 6'b101011: begin
                dec.aluc = ALU_ADDU; dec.use_imm = 1'b1; dec.imm_sext = 1'b1;
            end
            6'b000100, 6'b000101: dec.aluc = ALU_SUBU;
            default: dec.illegal = 1'b1;
        endcase
    end

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != 2'd0);
    // A flush cancels both handshakes on its edge.
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // After any pop, an empty buffer takes the new word straight into the head slot.
            if (push) begin
                if (count_d == 2'd0) head_d = dec;
                else                 tail_d = dec;
                count_d = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    entry_t head_out;
    assign head_out  = out_valid ? head_q : '0;
    assign aluc      = head_out.aluc;
    assign use_imm   = head_out.use_imm;
    assign imm_sext  = head_out.imm_sext;
    assign shift_var = head_out.shift_var;
    assign illegal   = head_out.illegal;

`ifdef ALUC_STATS_EN
    logic [CNT_W-1:0] issued_q, issued_d, ill_q, ill_d;

    always_comb begin
        issued_d = issued_q;
        ill_d    = ill_q;
        if (pop && issued_q != '1) issued_d = issued_q + CNT_W'(1);
        if (pop && head_q.illegal && ill_q != '1) ill_d = ill_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            ill_q    <= '0;
        end else begin
            issued_q <= issued_d;
            ill_q    <= ill_d;
        end
    end

    assign stat_issued  = issued_q;
    assign stat_illegal = ill_q;
`endif

endmodule

// File: tb/tb_alu_op_encoder.sv
// Bench for alu_op_encoder: decode vector table, directed buffer sequences and a
// randomized run against a queue-based FIFO model.
module tb_alu_op_encoder;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0] op, funct;
    logic [4:0] aluc;
    logic       use_imm, imm_sext, shift_var, illegal;
`ifdef ALUC_STATS_EN
    logic [15:0] stat_issued, stat_illegal;
`endif

    alu_op_encoder dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct(funct),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluc(aluc), .use_imm(use_imm), .imm_sext(imm_sext),
        .shift_var(shift_var), .illegal(illegal)
`ifdef ALUC_STATS_EN
        , .stat_issued(stat_issued), .stat_illegal(stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] aluc;
        logic       ui;
        logic       se;
        logic       sv;
        logic       ill;
    } vec_t;

    vec_t tbl[32];
    int   nv = 0;
    vec_t cur;
    vec_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_issued = 0;
    int   m_ill = 0;

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic [4:0] a,
                       input logic [3:0] fl);
        tbl[nv] = '{o, f, a, fl[3], fl[2], fl[1], fl[0]};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int idx);
        op    = tbl[idx].op;
        funct = tbl[idx].funct;
        cur   = tbl[idx];
    endtask

    // One clock: predict the handshakes from the model, advance the model, settle at negedge.
    task automatic cyc();
        bit push, pop;
        push = in_valid && (q.size() < 2) && !flush && !rst;
        pop  = (q.size() > 0) && out_ready && !flush && !rst;
        if (pop) begin
            if (m_issued < 65535) m_issued++;
            if (q[0].ill && m_ill < 65535) m_ill++;
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_issued = 0;
            m_ill = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(cur);
        end
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        bit v;
        v = (q.size() > 0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
        chk({tag, ".aluc"},      32'(aluc),      v ? 32'(q[0].aluc) : 32'd0);
        chk({tag, ".use_imm"},   32'(use_imm),   v ? 32'(q[0].ui)   : 32'd0);
        chk({tag, ".imm_sext"},  32'(imm_sext),  v ? 32'(q[0].se)   : 32'd0);
        chk({tag, ".shift_var"}, 32'(shift_var), v ? 32'(q[0].sv)   : 32'd0);
        chk({tag, ".illegal"},   32'(illegal),   v ? 32'(q[0].ill)  : 32'd0);
`ifdef ALUC_STATS_EN
        chk({tag, ".stat_issued"},  32'(stat_issued),  32'(m_issued));
        chk({tag, ".stat_illegal"}, 32'(stat_illegal), 32'(m_ill));
`endif
    endtask

    initial begin
        // flags = {use_imm, imm_sext, shift_var, illegal}
        add(6'b000000, 6'b100000, 5'b00001, 4'b0000);  // 0 add
        add(6'b000000, 6'b100001, 5'b00000, 4'b0000);  // 1 addu
        add(6'b000000, 6'b100010, 5'b00011, 4'b0000);  // 2 sub
        add(6'b000000, 6'b100011, 5'b00010, 4'b0000);  // 3 subu
        add(6'b000000, 6'b100100, 5'b00100, 4'b0000);  // 4 and
        add(6'b000000, 6'b100101, 5'b00101, 4'b0000);  // 5 or
        add(6'b000000, 6'b100110, 5'b00110, 4'b0000);  // 6 xor
        add(6'b000000, 6'b100111, 5'b00111, 4'b0000);  // 7 nor
        add(6'b000000, 6'b101010, 5'b01000, 4'b0000);  // 8 slt
        add(6'b000000, 6'b101011, 5'b01001, 4'b0000);  // 9 sltu
        add(6'b000000, 6'b000000, 5'b01100, 4'b0000);  // 10 sll
        add(6'b000000, 6'b000010, 5'b01101, 4'b0000);  // 11 srl
        add(6'b000000, 6'b000011, 5'b01110, 4'b0000);  // 12 sra
        add(6'b000000, 6'b000100, 5'b01100, 4'b0010);  // 13 sllv
        add(6'b000000, 6'b000110, 5'b01101, 4'b0010);  // 14 srlv
        add(6'b000000, 6'b000111, 5'b01110, 4'b0010);  // 15 srav
        add(6'b001000, 6'b101010, 5'b00001, 4'b1100);  // 16 addi
        add(6'b001001, 6'b000111, 5'b00000, 4'b1100);  // 17 addiu
        add(6'b001010, 6'b111111, 5'b01000, 4'b1100);  // 18 slti
        add(6'b001011, 6'b000100, 5'b01001, 4'b1100);  // 19 sltiu
        add(6'b001100, 6'b100000, 5'b00100, 4'b1000);  // 20 andi
        add(6'b001101, 6'b010101, 5'b00101, 4'b1000);  // 21 ori
        add(6'b001110, 6'b000000, 5'b00110, 4'b1000);  // 22 xori
        add(6'b001111, 6'b100111, 5'b10000, 4'b1000);  // 23 lui
        add(6'b100011, 6'b000011, 5'b00000, 4'b1100);  // 24 lw
        add(6'b101011, 6'b001001, 5'b00000, 4'b1100);  // 25 sw
        add(6'b000100, 6'b100010, 5'b00010, 4'b0000);  // 26 beq
        add(6'b000101, 6'b000110, 5'b00010, 4'b0000);  // 27 bne
        add(6'b000010, 6'b100000, 5'b00000, 4'b0001);  // 28 j
        add(6'b000000, 6'b001000, 5'b00000, 4'b0001);  // 29 jr (not ALU)
        add(6'b100000, 6'b100000, 5'b00000, 4'b0001);  // 30 lb
        add(6'b000000, 6'b000001, 5'b00000, 4'b0001);  // 31 undefined funct

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in(0);
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready",  32'(in_ready),  32'd1);
        chk("reset.aluc",      32'(aluc),      32'd0);
        check_outputs("reset");

        // Decode table: single push then pop, head checked against the table.
        for (int i = 0; i < nv; i++) begin
            set_in(i); in_valid = 1'b1; out_ready = 1'b0;
            cyc();
            in_valid = 1'b0;
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
            check_outputs($sformatf("vec%0d", i));
            out_ready = 1'b1;
            cyc();
            check_outputs($sformatf("vec%0d.pop", i));
        end
        out_ready = 1'b0;

        // nor with out_ready high: one-cycle latency then drain.
        set_in(7); in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("nor.out_valid", 32'(out_valid), 32'd1);
        chk("nor.aluc", 32'(aluc), 32'b00111);
        chk("nor.use_imm", 32'(use_imm), 32'd0);
        cyc();
        chk("nor.drained", 32'(out_valid), 32'd0);

        // Fill with ori, sltiu; lui must be refused while full.
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(21); cyc();
        set_in(19); cyc();
        chk("full.in_ready", 32'(in_ready), 32'd0);
        set_in(23); cyc();
        in_valid = 1'b0;
        chk("full.head_aluc", 32'(aluc), 32'b00101);
        chk("full.head_use_imm", 32'(use_imm), 32'd1);
        chk("full.head_sext", 32'(imm_sext), 32'd0);
        out_ready = 1'b1; cyc();
        chk("full.second_aluc", 32'(aluc), 32'b01001);
        chk("full.second_sext", 32'(imm_sext), 32'd1);
        cyc();
        chk("full.lui_refused", 32'(out_valid), 32'd0);
        check_outputs("full");

        // Count 1, simultaneous push srav and pop.
        out_ready = 1'b0; in_valid = 1'b1; set_in(10); cyc();
        out_ready = 1'b1; set_in(15); cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pp.out_valid", 32'(out_valid), 32'd1);
        chk("pp.in_ready", 32'(in_ready), 32'd1);
        chk("pp.aluc", 32'(aluc), 32'b01110);
        chk("pp.shift_var", 32'(shift_var), 32'd1);
        out_ready = 1'b1; cyc();
        chk("pp.drained", 32'(out_valid), 32'd0);

        // j is queued as illegal.
        in_valid = 1'b1; out_ready = 1'b0; set_in(28); cyc();
        in_valid = 1'b0;
        chk("j.illegal", 32'(illegal), 32'd1);
        chk("j.aluc", 32'(aluc), 32'd0);
        out_ready = 1'b1; cyc();
        check_outputs("j.pop");

        // Flush while full with in_valid high: nothing survives, nothing accepted.
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(0); cyc();
        set_in(1); cyc();
        chk("flush.pre_full", 32'(in_ready), 32'd0);
        flush = 1'b1; set_in(2); cyc();
        flush = 1'b0;
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0; cyc();
        chk("flush.no_accept", 32'(out_valid), 32'd0);
        check_outputs("flush");

        // Randomized traffic against the FIFO model.
        for (int n = 0; n < 1500; n++) begin
            check_outputs("rand");
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            set_in(int'($urandom_range(0, nv - 1)));
            cyc();
        end
        flush = 1'b0; in_valid = 1'b0;
        check_outputs("rand.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_encoder.md
Name: alu_op_encoder

Overview:
- Producer end of the ALU result-select path.
- Decodes MIPS opcode/funct pairs into the 5-bit aluc control word. aluc[4:2] drives the execute-stage result mux; aluc[1:0] drives the operation within each functional group.
- Decoded words are queued in a 2-entry buffer with valid/ready handshakes on both sides, so decode and execute stall independently.

Parameters:
- DEPTH, 2, buffer entries; only 2 is supported (skid buffer).
- CNT_W, 16, width of optional statistics counters.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous buffer clear (branch redirect)
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  buffer can accept
- op  input  6  instruction[31:26]
- funct  input  6  instruction[5:0]
- out_valid  output  1  head entry valid
- out_ready  input  1  execute consumes head
- aluc  output  5  head control word
- use_imm  output  1  B operand is the immediate
- imm_sext  output  1  immediate is sign-extended (else zero-extended)
- shift_var  output  1  shift amount from rs[4:0] (else shamt)
- illegal  output  1  head op is not an ALU op

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: buffer count=0, out_valid=0, aluc=0, use_imm=0, imm_sext=0, shift_var=0, illegal=0, in_ready=1.
- aluc encoding, arith group aluc[4:2]=000:
  - addu=00000, add=00001 (overflow-checked), subu=00010, sub=00011.
- logic group 001: and=00100, or=00101, xor=00110, nor=00111.
- compare group 010: slt=01000, sltu=01001.
- shift group 011: sll=01100, srl=01101, sra=01110.
- lui group 100: lui=10000.
- Group 101 is reserved; this block never emits it.
- R-type (op=000000) funct decode:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu
  - 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt, 101011 sltu
  - 000000/000010/000011 sll/srl/sra with shift_var=0
  - 000100/000110/000111 sllv/srlv/srav with shift_var=1
- I-type decode, all with use_imm=1:
  - addi 001000 → add, sext
  - addiu 001001 → addu, sext
  - slti 001010 → slt, sext
  - sltiu 001011 → sltu, sext
  - andi 001100, ori 001101, xori 001110 → logic, zext
  - lui 001111 → lui
  - lw 100011, sw 101011 → addu, sext
- beq 000100 and bne 000101 → subu with use_imm=0.
- Any other op/funct: aluc=00000, all flags 0, illegal=1. The entry is still queued; execute decides how to trap.
- Decode is combinational on the input side; the entry is written on the accepting edge.
- Latency: accepted on edge N; with an empty buffer, out_valid=1 after edge N (1 cycle).
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = (count<2). It is registered-equivalent and depends only on count, not on out_ready.
- Count 0: push only.
- Count 1: push, pop, or both. Simultaneous push+pop keeps count=1 and the new entry becomes head.
- Count 2: no push. Pop → count 1, the second entry advances to head.
- Order is strictly FIFO.
- Head outputs hold stable while out_valid=1 and out_ready=0.
- flush=1: count←0 on that edge. A concurrent push or pop is discarded, and the in_valid instruction is not accepted even though in_ready was 1.
- rst has priority over flush.
- Output fields when out_valid=0: all outputs are driven 0.

Optional Feature:
- Macro ALUC_STATS_EN.
- When defined, adds outputs stat_issued[CNT_W-1:0] and stat_illegal[CNT_W-1:0].
  - stat_issued increments on each pop.
  - stat_illegal increments on each pop whose head has illegal=1.
  - Both saturate at all-ones and clear on rst only (not on flush).
- When undefined, these ports and counters are absent; the core behaviour is identical.

Test Plan:
- rst held 2 cycles, then released → out_valid=0, aluc=00000, in_ready=1, and all flags 0.
- Push op=000000 funct=100111 with out_ready=1 → next cycle out_valid=1, aluc=00111, use_imm=0. Pop, then out_valid=0.
- out_ready=0; push ori (001101), sltiu (001011), then attempt lui:
  - in_ready=0 after the 2nd push, so lui is not accepted.
  - Head is 00101 (use_imm=1, imm_sext=0), then 01001 (imm_sext=1) after a pop.
- Count=1, simultaneous push srav (funct 000111) and pop → count stays 1; the next head is aluc=01110 with shift_var=1.
- Push op=000010 (j) → head illegal=1, aluc=00000. With ALUC_STATS_EN, stat_illegal=1 after the pop and stat_issued increments.
- Count=2 with flush=1 and in_valid=1 on the same edge → out_valid=0 and count=0; no entry is accepted; stats are unchanged by the flush.
